// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds, occupancy count
// and sticky overflow/underflow flags. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_prog #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_wren,
  input  logic [DATA_W-1:0] i_wrdata,
  input  logic              i_rden,
  input  logic [CNT_W-1:0]  i_alm_full_th,
  input  logic [CNT_W-1:0]  i_alm_empty_th,
  input  logic              i_clr_err,
  output logic [DATA_W-1:0] o_rddata,
  output logic              o_empty,
  output logic              o_alm_empty,
  output logic              o_full,
  output logic              o_alm_full,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic              wr_acc;
  logic              rd_acc;

  // Acceptance looks only at the registered flags, so full+rd+wr pops only and empty+rd+wr pushes only.
  always_comb begin
    wr_acc    = i_wren & ~o_full;
    rd_acc    = i_rden & ~o_empty;
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_empty     <= 1'b1;
      o_alm_empty <= 1'b1;
      o_full      <= 1'b0;
      o_alm_full  <= 1'b0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
      count       <= count_nxt;
      o_empty     <= (count_nxt == '0);
      o_full      <= (count_nxt == CNT_W'(DEPTH));
      o_alm_empty <= (count_nxt <= i_alm_empty_th);
      o_alm_full  <= (count_nxt >= i_alm_full_th);
      // A new error event outranks a clear in the same cycle.
      if (i_wren && o_full)       o_overflow  <= 1'b1;
      else if (i_clr_err)         o_overflow  <= 1'b0;
      if (i_rden && o_empty)      o_underflow <= 1'b1;
      else if (i_clr_err)         o_underflow <= 1'b0;
    end
  end

  // Storage is not reset; pointers returning to zero make old contents unreachable.
  always_ff @(posedge clk) begin
    if (rstn && wr_acc) mem[wr_ptr] <= i_wrdata;
  end

  assign o_count = count;

`ifdef SYNC_FIFO_FWFT_EN
  assign o_rddata = o_empty ? '0 : mem[rd_ptr];
`else
  logic [DATA_W-1:0] rddata_q;

  always_ff @(posedge clk) begin
    if (!rstn)       rddata_q <= '0;
    else if (rd_acc) rddata_q <= mem[rd_ptr];
  end

  assign o_rddata = rddata_q;
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench for sync_fifo_prog (DATA_W=8, DEPTH=16) against a queue-based reference.
// Honours SYNC_FIFO_FWFT_EN for the expected read-data timing.
module tb_sync_fifo_prog;

  logic       clk = 1'b0;
  logic       rstn;
  logic       wren;
  logic [7:0] wdata;
  logic       rden;
  logic [4:0] afth;
  logic [4:0] aeth;
  logic       clr;
  logic [7:0] rddata;
  logic       empty, alm_empty, full, alm_full, ovf, unf;
  logic [4:0] count;

  int total = 0;
  int bad   = 0;

  // Reference state: contents as a queue, plus the registered flags and read word.
  logic [7:0] q[$];
  logic [7:0] m_rd;
  bit         m_rd_valid;
  bit         m_ae, m_af, m_ovf, m_unf;
  logic [10:0] exp_st;
  logic [10:0] obs_st;

  always #5 clk = ~clk;

  sync_fifo_prog #(.DATA_W(8), .DEPTH(16)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .i_wren         (wren),
    .i_wrdata       (wdata),
    .i_rden         (rden),
    .i_alm_full_th  (afth),
    .i_alm_empty_th (aeth),
    .i_clr_err      (clr),
    .o_rddata       (rddata),
    .o_empty        (empty),
    .o_alm_empty    (alm_empty),
    .o_full         (full),
    .o_alm_full     (alm_full),
    .o_count        (count),
    .o_overflow     (ovf),
    .o_underflow    (unf)
  );

  assign obs_st = {count, empty, alm_empty, full, alm_full, ovf, unf};

  // Advance the reference by one clock using the inputs as currently driven, then step the DUT.
  task automatic step();
    bit is_full, is_empty;
    is_full  = (q.size() == 16);
    is_empty = (q.size() == 0);
    if (!rstn) begin
      q.delete();
      m_rd = 8'h00; m_ovf = 0; m_unf = 0; m_ae = 1; m_af = 0;
    end else begin
      if (rden && !is_empty) m_rd = q.pop_front();
      if (wren && !is_full)  q.push_back(wdata);
      if (wren && is_full)   m_ovf = 1; else if (clr) m_ovf = 0;
      if (rden && is_empty)  m_unf = 1; else if (clr) m_unf = 0;
      m_ae = (q.size() <= aeth);
      m_af = (q.size() >= afth);
    end
`ifdef SYNC_FIFO_FWFT_EN
    m_rd_valid = (q.size() != 0);
    if (m_rd_valid) m_rd = q[0];
`else
    m_rd_valid = 1;
`endif
    exp_st = {5'(q.size()), q.size() == 0, m_ae, q.size() == 16, m_af, m_ovf, m_unf};
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wren = 0; rden = 0; clr = 0; wdata = 8'h00;
  endtask

  task automatic test_reset();
    rstn = 0; wren = 1; rden = 1; wdata = 8'hAA; clr = 0;
    step();
    rstn = 1; idle_inputs();
    step();
    total++;
    if (obs_st !== 11'b00000_110000) begin
      bad++; $display("FAIL reset_status got=%b exp=%b", obs_st, 11'b00000_110000);
    end
    total++;
    if (rddata !== 8'h00) begin
      bad++; $display("FAIL reset_rddata got=%h exp=00", rddata);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 17; i++) begin
      wren = 1; wdata = 8'(i);
      step();
      total++;
      if (obs_st !== exp_st) begin
        bad++; $display("FAIL fill[%0d] status got=%b exp=%b", i, obs_st, exp_st);
      end
    end
    idle_inputs();
    total++;
    if ({full, count, ovf} !== {1'b1, 5'd16, 1'b1}) begin
      bad++; $display("FAIL fill_overflow got full=%b count=%0d ovf=%b exp 1/16/1", full, count, ovf);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 17; i++) begin
      rden = 1;
      step();
      total++;
      if (obs_st !== exp_st) begin
        bad++; $display("FAIL drain[%0d] status got=%b exp=%b", i, obs_st, exp_st);
      end
      if (m_rd_valid) begin
        total++;
        if (rddata !== m_rd) begin
          bad++; $display("FAIL drain[%0d] data got=%h exp=%h", i, rddata, m_rd);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_simultaneous();
    clr = 1;
    step();
    clr = 0;
    for (int i = 0; i < 16; i++) begin
      wren = 1; wdata = 8'($urandom);
      step();
    end
    wren = 1; rden = 1; wdata = 8'($urandom);
    step();
    total++;
    if (obs_st !== exp_st || count !== 5'd15) begin
      bad++; $display("FAIL simul_full status got=%b exp=%b", obs_st, exp_st);
    end
    total++;
    if (m_rd_valid && rddata !== m_rd) begin
      bad++; $display("FAIL simul_full data got=%h exp=%h", rddata, m_rd);
    end
    wren = 0;
    for (int i = 0; i < 15; i++) step();
    wren = 1; rden = 1; wdata = 8'($urandom);
    step();
    total++;
    if (obs_st !== exp_st || count !== 5'd1) begin
      bad++; $display("FAIL simul_empty status got=%b exp=%b", obs_st, exp_st);
    end
    idle_inputs();
  endtask

  task automatic test_interleave();
    int  nw = 0;
    int  nr = 0;
    bit  can_w, can_r;
    aeth = 5'd4;
    for (int it = 0; it < 400 && (nw < 40 || nr < 40); it++) begin
      can_w = (nw < 40) && (q.size() < 10);
      can_r = (nr < 40) && ((q.size() > 3) || (nw == 40));
      wren  = can_w && ($urandom_range(0, 1) == 1);
      rden  = can_r && ($urandom_range(0, 1) == 1);
      if (!wren && !rden) begin
        if (can_w) wren = 1; else rden = can_r;
      end
      if (it == 20) aeth = 5'd8;
      wdata = 8'($urandom);
      if (wren) nw++;
      if (rden) nr++;
      step();
      total++;
      if (obs_st !== exp_st) begin
        bad++; $display("FAIL interleave[%0d] status got=%b exp=%b", it, obs_st, exp_st);
      end
      if (m_rd_valid) begin
        total++;
        if (rddata !== m_rd) begin
          bad++; $display("FAIL interleave[%0d] data got=%h exp=%h", it, rddata, m_rd);
        end
      end
    end
    idle_inputs();
    aeth = 5'd4;
  endtask

  task automatic test_err_clear_reset();
    while (q.size() < 16) begin
      wren = 1; wdata = 8'($urandom);
      step();
    end
    step();
    total++;
    if (ovf !== 1'b1) begin
      bad++; $display("FAIL ovf_set got=%b exp=1", ovf);
    end
    clr = 1;
    step();
    total++;
    if (ovf !== 1'b1 || obs_st !== exp_st) begin
      bad++; $display("FAIL clr_vs_set got=%b exp=%b", obs_st, exp_st);
    end
    wren = 0;
    step();
    total++;
    if (ovf !== 1'b0 || obs_st !== exp_st) begin
      bad++; $display("FAIL clr_clean got=%b exp=%b", obs_st, exp_st);
    end
    clr = 0;
    for (int i = 0; i < 4; i++) begin
      rden = 1; wren = (i % 2 == 0); wdata = 8'($urandom);
      step();
    end
    rstn = 0; wren = 1; rden = 1; wdata = 8'h5A;
    step();
    rstn = 1; idle_inputs();
    total++;
    if (obs_st !== 11'b00000_110000 || obs_st !== exp_st) begin
      bad++; $display("FAIL midreset_status got=%b exp=%b", obs_st, 11'b00000_110000);
    end
    total++;
    if (rddata !== 8'h00) begin
      bad++; $display("FAIL midreset_rddata got=%h exp=00", rddata);
    end
    wren = 1; wdata = 8'hC3;
    step();
    wren = 0; rden = 1;
    step();
    rden = 0;
    total++;
    if (obs_st !== exp_st || rddata !== 8'hC3) begin
      bad++; $display("FAIL post_reset got=%b/%h exp=%b/c3", obs_st, rddata, exp_st);
    end
  endtask

  initial begin
    rstn = 0; afth = 5'd14; aeth = 5'd4;
    idle_inputs();
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_interleave();
    test_err_clear_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
